// File: rtl/snake_vga_top.sv
// Autonomous Snake demo: 640x480@60 Hz VGA timing with a 40x30 grid of 16x16 cells,
// a border, one food cell and a 4-segment snake that advances in raster order.
module snake_vga_top #(
  parameter int unsigned CLK_DIV     = 4,
  parameter int unsigned MOVE_FRAMES = 8,
  parameter int unsigned FOOD_COL0   = 20,
  parameter int unsigned FOOD_ROW0   = 15
) (
  input  logic       clk,
  input  logic       rst,
  output logic [2:0] vgaRed,
  output logic [2:0] vgaGreen,
  output logic [1:0] vgaBlue,
  output logic       Hsync,
  output logic       Vsync
);

  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
  localparam logic [7:0] FrameLast = 8'(MOVE_FRAMES - 1);

  localparam logic [9:0] HLast   = 10'd799;
  localparam logic [9:0] HVis    = 10'd640;
  localparam logic [9:0] HSyncS  = 10'd656;
  localparam logic [9:0] HSyncE  = 10'd751;
  localparam logic [9:0] VLast   = 10'd524;
  localparam logic [9:0] VVis    = 10'd480;
  localparam logic [9:0] VSyncS  = 10'd490;
  localparam logic [9:0] VSyncE  = 10'd491;

  localparam logic [7:0] RgbHead   = 8'b111_111_00;
  localparam logic [7:0] RgbBody   = 8'b000_111_00;
  localparam logic [7:0] RgbFood   = 8'b111_000_00;
  localparam logic [7:0] RgbBorder = 8'b111_111_11;

  logic [DivW-1:0] r_div, w_div_nxt;
  logic            w_pix_en;
  logic [9:0]      r_hcount, r_vcount, w_hcount_nxt, w_vcount_nxt;
  logic            w_h_end, w_v_end, w_tick, w_step, w_eat;

  logic [7:0]      r_frame, w_frame_nxt;
  logic [5:0]      r_seg_col [4];
  logic [4:0]      r_seg_row [4];
  logic [5:0]      r_food_col, w_food_col_nxt;
  logic [4:0]      r_food_row, w_food_row_nxt;
  logic [6:0]      w_fc_sum;
  logic [5:0]      w_fr_sum;
  logic [5:0]      w_head_col;
  logic [4:0]      w_head_row;

  logic [5:0]      w_cell_col;
  logic [4:0]      w_cell_row;
  logic            w_is_head, w_is_body, w_is_food, w_is_border, w_visible;
  logic [7:0]      w_rgb, r_rgb;
  logic            r_hsync, r_vsync;

  // Timing counters and pixel divider
  always_comb begin
    w_pix_en     = (r_div == DivLast);
    w_div_nxt    = w_pix_en ? '0 : r_div + 1'b1;
    w_h_end      = (r_hcount == HLast);
    w_v_end      = (r_vcount == VLast);
    w_tick       = w_pix_en && w_h_end && w_v_end;
    w_hcount_nxt = r_hcount;
    w_vcount_nxt = r_vcount;
    if (w_pix_en) begin
      w_hcount_nxt = w_h_end ? 10'd0 : r_hcount + 10'd1;
      if (w_h_end) begin
        w_vcount_nxt = w_v_end ? 10'd0 : r_vcount + 10'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_div    <= '0;
      r_hcount <= '0;
      r_vcount <= '0;
    end else begin
      r_div    <= w_div_nxt;
      r_hcount <= w_hcount_nxt;
      r_vcount <= w_vcount_nxt;
    end
  end

  // Snake movement and food relocation
  always_comb begin
    w_frame_nxt = r_frame;
    w_step      = 1'b0;
    if (w_tick) begin
      if (r_frame == FrameLast) begin
        w_frame_nxt = 8'd0;
        w_step      = 1'b1;
      end else begin
        w_frame_nxt = r_frame + 8'd1;
      end
    end

    w_head_col = r_seg_col[0] + 6'd1;
    w_head_row = r_seg_row[0];
    if (r_seg_col[0] == 6'd39) begin
      w_head_col = 6'd0;
      w_head_row = (r_seg_row[0] == 5'd29) ? 5'd0 : r_seg_row[0] + 5'd1;
    end
    w_eat = w_step && (w_head_col == r_food_col) && (w_head_row == r_food_row);

    w_fc_sum       = {1'b0, r_food_col} + 7'd17;
    w_fr_sum       = {1'b0, r_food_row} + 6'd11;
    w_food_col_nxt = (w_fc_sum >= 7'd40) ? 6'(w_fc_sum - 7'd40) : w_fc_sum[5:0];
    w_food_row_nxt = (w_fr_sum >= 6'd30) ? 5'(w_fr_sum - 6'd30) : w_fr_sum[4:0];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_frame <= '0;
      for (int i = 0; i < 4; i++) begin
        r_seg_col[i] <= 6'(10 - i);
        r_seg_row[i] <= 5'd15;
      end
      r_food_col <= 6'(FOOD_COL0);
      r_food_row <= 5'(FOOD_ROW0);
    end else begin
      r_frame <= w_frame_nxt;
      if (w_step) begin
        r_seg_col[0] <= w_head_col;
        r_seg_row[0] <= w_head_row;
        for (int i = 1; i < 4; i++) begin
          r_seg_col[i] <= r_seg_col[i-1];
          r_seg_row[i] <= r_seg_row[i-1];
        end
      end
      if (w_eat) begin
        r_food_col <= w_food_col_nxt;
        r_food_row <= w_food_row_nxt;
      end
    end
  end

  // Pixel colour from the pre-increment counters
  always_comb begin
    w_cell_col  = r_hcount[9:4];
    w_cell_row  = r_vcount[8:4];
    w_visible   = (r_hcount < HVis) && (r_vcount < VVis);
    w_is_head   = (w_cell_col == r_seg_col[0]) && (w_cell_row == r_seg_row[0]);
    w_is_body   = 1'b0;
    for (int i = 1; i < 4; i++) begin
      if ((w_cell_col == r_seg_col[i]) && (w_cell_row == r_seg_row[i])) begin
        w_is_body = 1'b1;
      end
    end
    w_is_food   = (w_cell_col == r_food_col) && (w_cell_row == r_food_row);
    w_is_border = (w_cell_col == 6'd0) || (w_cell_col == 6'd39) ||
                  (w_cell_row == 5'd0) || (w_cell_row == 5'd29);
    w_rgb = 8'h00;
    if (w_visible) begin
      if (w_is_head)        w_rgb = RgbHead;
      else if (w_is_body)   w_rgb = RgbBody;
      else if (w_is_food)   w_rgb = RgbFood;
      else if (w_is_border) w_rgb = RgbBorder;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rgb   <= 8'h00;
      r_hsync <= 1'b1;
      r_vsync <= 1'b1;
    end else if (w_pix_en) begin
      r_rgb   <= w_rgb;
      r_hsync <= !((r_hcount >= HSyncS) && (r_hcount <= HSyncE));
      r_vsync <= !((r_vcount >= VSyncS) && (r_vcount <= VSyncE));
    end
  end

  assign vgaRed   = r_rgb[7:5];
  assign vgaGreen = r_rgb[4:2];
  assign vgaBlue  = r_rgb[1:0];
  assign Hsync    = r_hsync;
  assign Vsync    = r_vsync;

endmodule

// File: tb/tb_snake_vga_top.sv
// Directed bench for snake_vga_top: sync timing from reset, colour of chosen pixels,
// snake steps every 8 frame ticks, food relocation and mid-frame reset.
module tb_snake_vga_top;

  localparam logic [7:0] Yel = 8'hFC;
  localparam logic [7:0] Grn = 8'h1C;
  localparam logic [7:0] Red = 8'hE0;
  localparam logic [7:0] Wht = 8'hFF;
  localparam logic [7:0] Blk = 8'h00;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] vgaRed, vgaGreen;
  logic [1:0] vgaBlue;
  logic       Hsync, Vsync;
  logic [7:0] rgb;

  int unsigned n_clk = 0;
  int          n_total = 0;
  int          n_bad = 0;
  logic [9:0]  f_h, f_v;

  snake_vga_top #(
    .CLK_DIV    (4),
    .MOVE_FRAMES(8),
    .FOOD_COL0  (20),
    .FOOD_ROW0  (15)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .vgaRed  (vgaRed),
    .vgaGreen(vgaGreen),
    .vgaBlue (vgaBlue),
    .Hsync   (Hsync),
    .Vsync   (Vsync)
  );

  assign rgb = {vgaRed, vgaGreen, vgaBlue};

  always #5 clk = ~clk;

  // Clocks since reset release; pixel enables fall on multiples of 4
  always @(posedge clk) begin
    if (!rst) n_clk <= 0;
    else      n_clk <= n_clk + 1;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Returns n_clk when the selected sync reaches lvl, or -1 if the limit expires
  task automatic wait_sync(input bit vs, input logic lvl, input int limit, output int at);
    at = -1;
    for (int i = 0; i < limit; i++) begin
      if ((vs ? Vsync : Hsync) == lvl) begin
        at = int'(n_clk);
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_clk(input int unsigned target);
    while (n_clk < target) @(negedge clk);
  endtask

  // Jump the raster to (h,v) over a non-enable edge; returns once outputs show that pixel
  task automatic goto_px(input int h, input int v);
    do @(negedge clk); while (n_clk % 4 != 0);
    f_h = 10'(h);
    f_v = 10'(v);
    force dut.r_hcount = f_h;
    force dut.r_vcount = f_v;
    @(negedge clk);
    release dut.r_hcount;
    release dut.r_vcount;
    repeat (3) @(negedge clk);
  endtask

  task automatic px(input string tag, input int h, input int v, input logic [7:0] exp);
    goto_px(h, v);
    check(tag, 32'(rgb), 32'(exp));
  endtask

  task automatic tick();
    goto_px(799, 524);
  endtask

  int t0, t1, t2;

  initial begin
    // Reset held: outputs idle every clock
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("rst_hold", 32'({Hsync, Vsync, rgb}), 32'({2'b11, 8'h00}));
    end
    rst = 1'b1;

    // Natural raster timing from release
    wait_sync(1'b0, 1'b0, 4000, t0);
    check("hs_fall", 32'(t0), 32'd2628);
    wait_sync(1'b0, 1'b1, 1000, t1);
    check("hs_low_clks", 32'(t1 - t0), 32'd384);
    wait_sync(1'b0, 1'b0, 4000, t2);
    check("line_clks", 32'(t2 - t0), 32'd3200);
    check("vs_idle", 32'(Vsync), 32'd1);
    wait_clk(16024);
    check("px_5_5", 32'(rgb), 32'(Wht));
    wait_clk(18560);
    check("px_639_5", 32'(rgb), 32'(Wht));
    wait_clk(18564);
    check("px_640_5", 32'(rgb), 32'(Blk));
    wait_clk(18804);
    check("px_700_5", 32'(rgb), 32'(Blk));

    // Initial scene
    px("head0", 168, 248, Yel);
    px("tail0", 120, 240, Grn);
    px("food0", 328, 248, Red);
    px("black0", 300, 100, Blk);
    px("left_of_tail", 104, 240, Blk);
    px("border_c39", 632, 240, Wht);
    px("border_r29", 8, 470, Wht);
    px("food_dst0", 592, 416, Blk);

    // Vertical sync: two lines starting at line 490
    goto_px(799, 489);
    check("vs_pre", 32'(Vsync), 32'd1);
    t0 = int'(n_clk);
    wait_sync(1'b1, 1'b0, 20, t1);
    check("vs_fall_dly", 32'(t1 - t0), 32'd4);
    wait_sync(1'b1, 1'b1, 8000, t2);
    check("vs_low_clks", 32'(t2 - t1), 32'd6400);

    // Frame wrap (first tick) lands on the white top-left border
    tick();
    check("blank_799_524", 32'(rgb), 32'(Blk));
    repeat (4) @(negedge clk);
    check("wrap_0_0", 32'(rgb), 32'(Wht));

    repeat (6) tick();
    px("no_step_7", 168, 248, Yel);
    tick();
    px("step1_head", 184, 248, Yel);
    px("step1_seg1", 168, 248, Grn);
    px("step1_tail", 136, 240, Grn);
    px("step1_old", 120, 240, Blk);

    // Nine more steps: head lands on the food
    repeat (72) tick();
    px("eat_head", 328, 248, Yel);
    px("eat_seg1", 312, 248, Grn);
    px("eat_food", 592, 416, Red);
    px("eat_old", 136, 248, Blk);
    repeat (8) tick();
    px("after_head", 344, 248, Yel);
    px("after_seg1", 328, 248, Grn);
    px("after_food", 592, 416, Red);

    // Run to the right edge and wrap onto the next row
    repeat (144) tick();
    px("edge_head", 632, 248, Yel);
    repeat (8) tick();
    px("wrap_head", 8, 264, Yel);
    px("wrap_seg1", 632, 248, Grn);
    px("wrap_tail", 600, 248, Grn);
    px("wrap_old", 584, 248, Blk);
    px("wrap_row16", 24, 264, Blk);

    // Mid-frame reset while both syncs are asserted
    goto_px(660, 490);
    check("pre_rst_sync", 32'({Hsync, Vsync}), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_now", 32'({Hsync, Vsync, rgb}), 32'({2'b11, 8'h00}));
    repeat (9) @(negedge clk);
    check("rst_held", 32'({Hsync, Vsync, rgb}), 32'({2'b11, 8'h00}));
    rst = 1'b1;
    wait_sync(1'b0, 1'b0, 4000, t0);
    check("hs_fall_rst", 32'(t0), 32'd2628);
    px("rst_head", 168, 248, Yel);
    px("rst_old_head", 184, 248, Blk);
    px("rst_border", 8, 264, Wht);
    px("rst_food", 328, 248, Red);
    px("rst_food_dst", 592, 416, Blk);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
